// File: rtl/logic_unit_if.sv
// Handshake bundle for logic_unit_pipe: operand side, result side, counters.
// Flag signals exist only when LU_FLAGS_EN is defined.
interface logic_unit_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2:0]         in_op;
  logic               in_acc;
  logic               acc_clr;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [COUNT_W-1:0] op_count;
`ifdef LU_FLAGS_EN
  logic               out_zero;
  logic               out_parity;
`endif

  modport master (
`ifdef LU_FLAGS_EN
    input  out_zero, out_parity,
`endif
    output in_valid, in_a, in_b, in_op,
    output in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_data,
    input  op_count
  );

  modport slave (
`ifdef LU_FLAGS_EN
    output out_zero, out_parity,
`endif
    input  in_valid, in_a, in_b, in_op,
    input  in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_data,
    output op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit 8-op bitwise logic unit as a 1-deep valid/ready stage with accumulator.
// Optional zero/parity flags with LU_FLAGS_EN.
module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  logic_unit_if.slave bus
);
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   data_q;
  logic [COUNT_W-1:0] count_q;
  logic               valid_q;
  logic               accept;

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign b_eff         = bus.in_acc ? acc : bus.in_b;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.op_count  = count_q;

  always_comb begin
    result = '0;
    unique case (bus.in_op)
      3'b000: result = bus.in_a & b_eff;
      3'b001: result = bus.in_a | b_eff;
      3'b010: result = bus.in_a ^ b_eff;
      3'b011: result = ~(bus.in_a & b_eff);
      3'b100: result = ~(bus.in_a | b_eff);
      3'b101: result = ~(bus.in_a ^ b_eff);
      3'b110: result = ~bus.in_a;
      3'b111: result = bus.in_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= result;
      count_q <= count_q + 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Clear wins over a same-cycle accumulate; the op itself used the old acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (bus.acc_clr) begin
      acc <= '0;
    end else if (accept && bus.in_acc) begin
      acc <= result;
    end
  end

`ifdef LU_FLAGS_EN
  logic zero_q;
  logic parity_q;

  assign bus.out_zero   = zero_q;
  assign bus.out_parity = parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (accept) begin
      zero_q   <= ~|result;
      parity_q <= ^result;
    end
  end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, COUNT_W=8).
// Random traffic is checked against a truth-table reference model.
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic_unit_if #(.WIDTH(8), .COUNT_W(8)) bus ();

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Each op as a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [7:0] ref_op(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    logic [3:0] tt;
    logic [7:0] r;
    case (op)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic acc);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_acc   = acc;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    bus.acc_clr   = 0;
    bus.out_ready = 1;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", bus.out_data); end
    n_cmp++; if (bus.op_count !== 8'h00) begin n_fail++; $display("FAIL reset_count got %h want 00", bus.op_count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
`ifdef LU_FLAGS_EN
    n_cmp++; if (bus.out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", bus.out_zero); end
    n_cmp++; if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity got %b want 0", bus.out_parity); end
`endif
  endtask

  task automatic test_first();
    drive(1, 3'b000, 8'hF0, 8'h3C, 0);
    bus.out_ready = 1;
    step();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h30) begin n_fail++; $display("FAIL first_data got %h want 30", bus.out_data); end
    n_cmp++; if (bus.op_count !== 8'd1) begin n_fail++; $display("FAIL first_count got %h want 01", bus.op_count); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h30) begin n_fail++; $display("FAIL drain_hold got %h want 30", bus.out_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF,
                             8'h03, 8'h33, 8'h0F, 8'hF0};
    logic [7:0] base;
    base = bus.op_count;
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i), 8'hF0, 8'h3C, 0);
      step();
      n_cmp++; if (bus.out_data !== want[i] || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_op%0d got %h/%b want %h/1", i, bus.out_data, bus.out_valid, want[i]); end
      n_cmp++; if (bus.out_data !== ref_op(3'(i), 8'hF0, 8'h3C)) begin n_fail++; $display("FAIL sweep_ref%0d got %h", i, bus.out_data); end
    end
    n_cmp++; if (bus.op_count !== base + 8'd8) begin n_fail++; $display("FAIL sweep_count got %h want %h", bus.op_count, base + 8'd8); end
    drive(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_stall();
    logic [7:0] base;
    drive(1, 3'b000, 8'hF0, 8'h3C, 0);
    step();
    base = bus.op_count;
    bus.out_ready = 0;
    drive(1, 3'b001, 8'hF0, 8'h3C, 0);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.out_data !== 8'h30 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold got %h/%b want 30/1", bus.out_data, bus.out_valid); end
      n_cmp++; if (bus.op_count !== base) begin n_fail++; $display("FAIL stall_count got %h want %h", bus.op_count, base); end
    end
    bus.out_ready = 1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL unstall_ready got %b want 1", bus.in_ready); end
    step();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (bus.out_data !== 8'hFC) begin n_fail++; $display("FAIL unstall_data got %h want FC", bus.out_data); end
    n_cmp++; if (bus.op_count !== base + 8'd1) begin n_fail++; $display("FAIL unstall_count got %h want %h", bus.op_count, base + 8'd1); end
    step();
  endtask

  task automatic test_accumulate();
    logic [7:0] a_seq [3] = '{8'h01, 8'h02, 8'h04};
    logic [7:0] r_seq [3] = '{8'h01, 8'h03, 8'h07};
    bus.acc_clr = 1;
    step();
    bus.acc_clr = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'b001, a_seq[i], 8'($urandom), 1);
      step();
      n_cmp++; if (bus.out_data !== r_seq[i]) begin n_fail++; $display("FAIL acc_step%0d got %h want %h", i, bus.out_data, r_seq[i]); end
    end
    drive(1, 3'b111, 8'h08, 8'($urandom), 1);
    bus.acc_clr = 1;
    step();
    bus.acc_clr = 0;
    n_cmp++; if (bus.out_data !== 8'h08) begin n_fail++; $display("FAIL acc_clr_data got %h want 08", bus.out_data); end
    drive(1, 3'b001, 8'h00, 8'hFF, 1);
    step();
    n_cmp++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL acc_cleared got %h want 00", bus.out_data); end
    drive(0, 0, 0, 0, 0);
    step();
  endtask

`ifdef LU_FLAGS_EN
  task automatic test_flags();
    drive(1, 3'b000, 8'h0F, 8'hF0, 0);
    step();
    n_cmp++; if (bus.out_zero !== 1'b1 || bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL flags_and got z%b p%b want z1 p0", bus.out_zero, bus.out_parity); end
    drive(1, 3'b111, 8'h07, 8'h00, 0);
    step();
    n_cmp++; if (bus.out_zero !== 1'b0 || bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL flags_pass got z%b p%b want z0 p1", bus.out_zero, bus.out_parity); end
    drive(0, 0, 0, 0, 0);
    step();
  endtask
`endif

  task automatic test_random();
    logic       e_valid = 0;
    logic [7:0] e_data = 0;
    logic [7:0] e_acc = 0;
    logic [7:0] e_cnt = 0;
    logic       v, ordy, ia, clr, e_ready, acc_ok;
    logic [2:0] op;
    logic [7:0] a, b, res;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      ia   = $urandom_range(1);
      clr  = !v && ($urandom_range(7) == 0);
      op   = 3'($urandom);
      a    = 8'($urandom);
      b    = 8'($urandom);
      drive(v, op, a, b, ia);
      bus.out_ready = ordy;
      bus.acc_clr   = clr;
      #1;
      e_ready = !e_valid || ordy;
      n_cmp++; if (bus.in_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready n%0d got %b want %b", n, bus.in_ready, e_ready); end
      acc_ok = v && e_ready;
      res = ref_op(op, a, ia ? e_acc : b);
      step();
      if (acc_ok) begin
        e_valid = 1;
        e_data  = res;
        e_cnt   = e_cnt + 8'd1;
        if (ia) e_acc = res;
      end else if (e_valid && ordy) begin
        e_valid = 0;
      end
      if (clr) e_acc = 0;
      n_cmp++; if (bus.out_valid !== e_valid || bus.out_data !== e_data) begin n_fail++; $display("FAIL rnd_out n%0d got %b/%h want %b/%h", n, bus.out_valid, bus.out_data, e_valid, e_data); end
      n_cmp++; if (bus.op_count !== e_cnt) begin n_fail++; $display("FAIL rnd_count n%0d got %h want %h", n, bus.op_count, e_cnt); end
`ifdef LU_FLAGS_EN
      n_cmp++; if (bus.out_zero !== (e_data == 0) || bus.out_parity !== ^e_data) begin n_fail++; $display("FAIL rnd_flags n%0d got z%b p%b", n, bus.out_zero, bus.out_parity); end
`endif
    end
    drive(0, 0, 0, 0, 0);
    bus.acc_clr   = 0;
    bus.out_ready = 1;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, 3'($urandom), 8'($urandom), 8'($urandom), 0);
      step();
      if (i == 254) begin
        n_cmp++; if (bus.op_count !== 8'hFF) begin n_fail++; $display("FAIL wrap_ff got %h want FF", bus.op_count); end
      end
    end
    n_cmp++; if (bus.op_count !== 8'h00) begin n_fail++; $display("FAIL wrap_zero got %h want 00", bus.op_count); end
    drive(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_in_stall();
    drive(1, 3'b111, 8'hA5, 8'h00, 0);
    step();
    bus.out_ready = 0;
    drive(0, 0, 0, 0, 0);
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin n_fail++; $display("FAIL pre_rst got %b/%h want 1/A5", bus.out_valid, bus.out_data); end
    rst = 1;
    step();
    rst = 0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.op_count !== 8'h00) begin n_fail++; $display("FAIL rst_stall_count got %h want 00", bus.op_count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_stall_data got %h want 00", bus.out_data); end
  endtask

  initial begin
    test_reset();
    test_first();
    test_back_to_back();
    test_stall();
    test_accumulate();
`ifdef LU_FLAGS_EN
    test_flags();
`endif
    test_random();
    test_wrap();
    test_reset_in_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
